// File: rtl/armleocpu_axi_sram_target_pkg.sv
// Shared AXI codes and FSM state encoding for the AXI SRAM target.
//
// Contents:
//   BURST_*     AXI burst type codes (FIXED=0, INCR=1, WRAP=2)
//   RESP_*      AXI response codes (OKAY=0, SLVERR=2, DECERR=3)
//   state_t     target FSM states
//   wrap_len_ok legal WRAP burst lengths (2, 4, 8 or 16 beats)
package armleocpu_axi_sram_target_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRITE_RESP,
    ST_READ_ISSUE,
    ST_READ_DATA
  } state_t;

  // AXI len field encodes beats-1, so legal wrap lengths are 1, 3, 7, 15.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/armleocpu_axi_burst_addr.sv
// Combinational AXI beat address generator.
//
// Ports:
//   addr      in   current beat byte address
//   len       in   AXI burst length (beats-1)
//   size      in   AXI beat size (log2 bytes)
//   burst     in   AXI burst type
//   next_addr out  byte address of the following beat
//   wrap_err  out  WRAP burst with an illegal length
module armleocpu_axi_burst_addr
  import armleocpu_axi_sram_target_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  wrap_err
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    incr_addr = addr + step;
    // Wrap window is (len+1)<<size bytes; low bits roll over inside it.
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    wrap_err  = (burst == BURST_WRAP) && !wrap_len_ok(len);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = wrap_err ? incr_addr
                                        : ((addr & ~wrap_mask) | (incr_addr & wrap_mask));
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/armleocpu_axi_sram_target.sv
// AXI4 target in front of a single-port synchronous SRAM (1-cycle read latency).
// One outstanding burst; AW/AR arbitrated round-robin; out-of-window beats
// answer DECERR, illegal WRAP lengths answer SLVERR, neither touches memory.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   axi_aw* / axi_w*       write address / write data (client side)
//   axi_b*                 write response
//   axi_ar* / axi_r*       read address / read data
//   mem_cs, mem_we         SRAM strobe and write enable (we qualified by cs)
//   mem_addr               SRAM word address
//   mem_wdata, mem_wstrb   SRAM write data and byte enables
//   mem_rdata              SRAM read data, valid the cycle after a read strobe
module armleocpu_axi_sram_target
  import armleocpu_axi_sram_target_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      axi_awvalid,
  output logic                      axi_awready,
  input  logic [ADDR_WIDTH-1:0]     axi_awaddr,
  input  logic [7:0]                axi_awlen,
  input  logic [2:0]                axi_awsize,
  input  logic [1:0]                axi_awburst,
  input  logic                      axi_awlock,
  input  logic [ID_WIDTH-1:0]       axi_awid,
  input  logic [2:0]                axi_awprot,

  input  logic                      axi_wvalid,
  output logic                      axi_wready,
  input  logic [DATA_WIDTH-1:0]     axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   axi_wstrb,
  input  logic                      axi_wlast,

  output logic                      axi_bvalid,
  input  logic                      axi_bready,
  output logic [1:0]                axi_bresp,
  output logic [ID_WIDTH-1:0]       axi_bid,

  input  logic                      axi_arvalid,
  output logic                      axi_arready,
  input  logic [ADDR_WIDTH-1:0]     axi_araddr,
  input  logic [7:0]                axi_arlen,
  input  logic [2:0]                axi_arsize,
  input  logic [1:0]                axi_arburst,
  input  logic                      axi_arlock,
  input  logic [ID_WIDTH-1:0]       axi_arid,
  input  logic [2:0]                axi_arprot,

  output logic                      axi_rvalid,
  input  logic                      axi_rready,
  output logic [1:0]                axi_rresp,
  output logic                      axi_rlast,
  output logic [DATA_WIDTH-1:0]     axi_rdata,
  output logic [ID_WIDTH-1:0]       axi_rid,

  output logic                      mem_cs,
  output logic                      mem_we,
  output logic [$clog2(DEPTH)-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int                  STRB_W    = DATA_WIDTH / 8;
  localparam int                  MEM_AW    = $clog2(DEPTH);
  localparam int                  OFF_W     = $clog2(STRB_W);
  localparam logic [ADDR_WIDTH:0] WIN_BYTES = (ADDR_WIDTH+1)'(DEPTH * STRB_W);

  state_t                state_q, state_d;
  logic                  last_was_write;
  logic [ID_WIDTH-1:0]   id_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            cnt_q;
  logic                  decerr_seen;
  logic                  rd_first;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  grant_w, grant_r;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  wrap_err;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic                  beat_ok;
  logic [1:0]            beat_resp;
  logic                  beat_last;
  logic [DATA_WIDTH-1:0] rdata_fwd;

  logic unused_inputs;
  assign unused_inputs = ^{axi_awlock, axi_awprot, axi_arlock, axi_arprot, axi_wlast};

  armleocpu_axi_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_burst_addr (
    .addr      (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr),
    .wrap_err  (wrap_err)
  );

  // Per-beat window decode on the current beat address.
  assign offset    = addr_q - BASE_ADDR;
  assign in_range  = (addr_q >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
  assign beat_ok   = in_range && !wrap_err;
  assign beat_resp = wrap_err ? RESP_SLVERR : (in_range ? RESP_OKAY : RESP_DECERR);
  assign beat_last = (cnt_q == len_q);

  // mem_rdata is the SRAM's own output register, so it is forwarded on the
  // first data cycle and held in rdata_q for any backpressure cycles after.
  assign rdata_fwd = (axi_rresp == RESP_OKAY) ? mem_rdata : '0;
  assign axi_rdata = rd_first ? rdata_fwd : rdata_q;

  always_comb begin
    grant_w     = axi_awvalid && (!axi_arvalid || !last_was_write);
    grant_r     = axi_arvalid && !grant_w;
    state_d     = state_q;
    axi_awready = 1'b0;
    axi_arready = 1'b0;
    axi_wready  = 1'b0;
    mem_cs      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    // While reset is held nothing is granted and the SRAM is never strobed.
    if (rst_n) begin
      case (state_q)
        ST_IDLE: begin
          axi_awready = grant_w;
          axi_arready = grant_r;
          if (grant_w)      state_d = ST_WRITE;
          else if (grant_r) state_d = ST_READ_ISSUE;
        end
        ST_WRITE: begin
          axi_wready = 1'b1;
          if (axi_wvalid) begin
            if (beat_ok) begin
              mem_cs    = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = offset[OFF_W +: MEM_AW];
              mem_wdata = axi_wdata;
              mem_wstrb = axi_wstrb;
            end
            // Completion is counted; wlast is not trusted.
            if (beat_last) state_d = ST_WRITE_RESP;
          end
        end
        ST_WRITE_RESP: begin
          if (axi_bready) state_d = ST_IDLE;
        end
        ST_READ_ISSUE: begin
          if (beat_ok) begin
            mem_cs   = 1'b1;
            mem_addr = offset[OFF_W +: MEM_AW];
          end
          state_d = ST_READ_DATA;
        end
        ST_READ_DATA: begin
          if (axi_rready) state_d = axi_rlast ? ST_IDLE : ST_READ_ISSUE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_was_write <= 1'b0;
      id_q           <= '0;
      len_q          <= '0;
      size_q         <= '0;
      burst_q        <= '0;
      addr_q         <= '0;
      cnt_q          <= '0;
      decerr_seen    <= 1'b0;
      rd_first       <= 1'b0;
      rdata_q        <= '0;
      axi_bvalid     <= 1'b0;
      axi_bresp      <= RESP_OKAY;
      axi_bid        <= '0;
      axi_rvalid     <= 1'b0;
      axi_rresp      <= RESP_OKAY;
      axi_rlast      <= 1'b0;
      axi_rid        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q       <= '0;
          decerr_seen <= 1'b0;
          if (grant_w) begin
            last_was_write <= 1'b1;
            id_q           <= axi_awid;
            len_q          <= axi_awlen;
            size_q         <= axi_awsize;
            burst_q        <= axi_awburst;
            addr_q         <= axi_awaddr;
          end else if (grant_r) begin
            last_was_write <= 1'b0;
            id_q           <= axi_arid;
            len_q          <= axi_arlen;
            size_q         <= axi_arsize;
            burst_q        <= axi_arburst;
            addr_q         <= axi_araddr;
          end
        end
        ST_WRITE: begin
          if (axi_wvalid) begin
            if (!in_range) decerr_seen <= 1'b1;
            if (beat_last) begin
              axi_bvalid <= 1'b1;
              axi_bid    <= id_q;
              axi_bresp  <= wrap_err ? RESP_SLVERR
                          : ((decerr_seen || !in_range) ? RESP_DECERR : RESP_OKAY);
            end else begin
              cnt_q  <= cnt_q + 8'd1;
              addr_q <= next_addr;
            end
          end
        end
        ST_WRITE_RESP: begin
          if (axi_bready) axi_bvalid <= 1'b0;
        end
        ST_READ_ISSUE: begin
          axi_rvalid <= 1'b1;
          axi_rid    <= id_q;
          axi_rresp  <= beat_resp;
          axi_rlast  <= beat_last;
          rd_first   <= 1'b1;
        end
        ST_READ_DATA: begin
          rd_first <= 1'b0;
          if (rd_first) rdata_q <= rdata_fwd;
          if (axi_rready) begin
            axi_rvalid <= 1'b0;
            if (!axi_rlast) begin
              cnt_q  <= cnt_q + 8'd1;
              addr_q <= next_addr;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_axi_sram_target.sv
// Directed bench for armleocpu_axi_sram_target with a behavioural SRAM
// (word i preloaded with value i while reset is held).
module tb_armleocpu_axi_sram_target;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        axi_awvalid, axi_awready, axi_awlock;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize, axi_awprot;
  logic [1:0]  axi_awburst;
  logic [3:0]  axi_awid;
  logic        axi_wvalid, axi_wready, axi_wlast;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;
  logic [3:0]  axi_bid;
  logic        axi_arvalid, axi_arready, axi_arlock;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize, axi_arprot;
  logic [1:0]  axi_arburst;
  logic [3:0]  axi_arid;
  logic        axi_rvalid, axi_rready, axi_rlast;
  logic [1:0]  axi_rresp;
  logic [31:0] axi_rdata;
  logic [3:0]  axi_rid;
  logic        mem_cs, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  logic [31:0] sram [0:1023];
  int          cs_count = 0;
  int          cs_base;
  int          checks = 0;
  int          errors = 0;
  logic [9:0]  wrap_words [4];

  always #5 clk = ~clk;

  armleocpu_axi_sram_target dut (
    .clk(clk), .rst_n(rst_n),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awlock(axi_awlock), .axi_awid(axi_awid), .axi_awprot(axi_awprot),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arlock(axi_arlock), .axi_arid(axi_arid), .axi_arprot(axi_arprot),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rdata(axi_rdata), .axi_rid(axi_rid),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) sram[i] <= 32'(i);
      mem_rdata <= '0;
    end else if (mem_cs) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  always @(posedge clk) if (mem_cs) cs_count <= cs_count + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    wrap_words[0] = 10'd14; wrap_words[1] = 10'd15;
    wrap_words[2] = 10'd12; wrap_words[3] = 10'd13;
    rst_n = 1'b0;
    axi_awvalid = 0; axi_awaddr = 0; axi_awlen = 0; axi_awsize = 0; axi_awburst = 0;
    axi_awlock = 0; axi_awid = 0; axi_awprot = 0;
    axi_wvalid = 0; axi_wdata = 0; axi_wstrb = 0; axi_wlast = 0; axi_bready = 0;
    axi_arvalid = 0; axi_araddr = 0; axi_arlen = 0; axi_arsize = 0; axi_arburst = 0;
    axi_arlock = 0; axi_arid = 0; axi_arprot = 0; axi_rready = 0;

    // Reset
    repeat (3) tick();
    check("rst_awready", axi_awready, 0);
    check("rst_arready", axi_arready, 0);
    check("rst_wready", axi_wready, 0);
    check("rst_bvalid", axi_bvalid, 0);
    check("rst_rvalid", axi_rvalid, 0);
    check("rst_mem_cs", mem_cs, 0);
    rst_n = 1'b1;
    tick();
    check("rst_rdata", axi_rdata, 0);
    check("rst_bresp", axi_bresp, 0);

    // Simultaneous AW/AR: write wins first
    axi_awvalid = 1; axi_awaddr = 32'h10; axi_awlen = 3; axi_awsize = 2; axi_awburst = 1; axi_awid = 3;
    axi_arvalid = 1; axi_araddr = 32'h38; axi_arlen = 3; axi_arsize = 2; axi_arburst = 2; axi_arid = 5;
    #1;
    check("arb1_awready", axi_awready, 1);
    check("arb1_arready", axi_arready, 0);
    tick();
    axi_awvalid = 0;
    #1;
    check("wr_busy_arready", axi_arready, 0);

    // INCR write 0x10, 4 beats
    for (int i = 0; i < 4; i++) begin
      axi_wvalid = 1; axi_wdata = 32'(i + 1); axi_wstrb = 4'hF; axi_wlast = (i == 3);
      #1;
      check("wr_mem_cs", mem_cs, 1);
      check("wr_mem_we", mem_we, 1);
      check("wr_mem_addr", mem_addr, 4 + i);
      check("wr_mem_wdata", mem_wdata, i + 1);
      check("wr_mem_wstrb", mem_wstrb, 4'hF);
      check("wr_bvalid_early", axi_bvalid, 0);
      tick();
    end
    axi_wvalid = 0; axi_wlast = 0;
    check("wr_bvalid", axi_bvalid, 1);
    check("wr_bresp", axi_bresp, 0);
    check("wr_bid", axi_bid, 3);
    axi_bready = 1;
    axi_awvalid = 1; axi_awaddr = 32'h0; axi_awlen = 2; axi_awsize = 2; axi_awburst = 2; axi_awid = 7;
    tick();
    axi_bready = 0;
    #1;
    check("b_done_bvalid", axi_bvalid, 0);
    check("arb2_arready", axi_arready, 1);
    check("arb2_awready", axi_awready, 0);
    tick();
    axi_arvalid = 0;

    // WRAP read 0x38: words 14,15,12,13; backpressure on beat 1
    for (int b = 0; b < 4; b++) begin
      check("wrap_mem_cs", mem_cs, 1);
      check("wrap_mem_we", mem_we, 0);
      check("wrap_mem_addr", mem_addr, wrap_words[b]);
      check("wrap_rvalid_issue", axi_rvalid, 0);
      check("wrap_busy_awready", axi_awready, 0);
      tick();
      if (b == 1) begin
        for (int k = 0; k < 5; k++) begin
          check("bp_rvalid", axi_rvalid, 1);
          check("bp_rdata", axi_rdata, 15);
          tick();
        end
      end
      axi_rready = 1;
      #1;
      check("wrap_rvalid", axi_rvalid, 1);
      check("wrap_rdata", axi_rdata, 32'(wrap_words[b]));
      check("wrap_rid", axi_rid, 5);
      check("wrap_rresp", axi_rresp, 0);
      check("wrap_rlast", axi_rlast, (b == 3));
      tick();
      axi_rready = 0;
    end

    // Pending bad-WRAP write (len 2): SLVERR, no memory strobes
    #1;
    check("arb3_awready", axi_awready, 1);
    tick();
    axi_awvalid = 0;
    for (int i = 0; i < 3; i++) begin
      axi_wvalid = 1; axi_wdata = 32'hDEAD0000 + 32'(i); axi_wstrb = 4'hF; axi_wlast = (i == 2);
      #1;
      check("badw_wready", axi_wready, 1);
      check("badw_mem_cs", mem_cs, 0);
      tick();
    end
    axi_wvalid = 0; axi_wlast = 0;
    check("badw_bvalid", axi_bvalid, 1);
    check("badw_bresp", axi_bresp, 2);
    check("badw_bid", axi_bid, 7);
    axi_bready = 1;
    tick();
    axi_bready = 0;

    // Out-of-range: last word then one past the window
    cs_base = cs_count;
    axi_arvalid = 1; axi_araddr = 32'hFFC; axi_arlen = 1; axi_arsize = 2; axi_arburst = 1; axi_arid = 9;
    #1;
    check("oor_arready", axi_arready, 1);
    tick();
    axi_arvalid = 0;
    check("oor0_mem_cs", mem_cs, 1);
    check("oor0_mem_addr", mem_addr, 1023);
    tick();
    axi_rready = 1;
    #1;
    check("oor0_rdata", axi_rdata, 1023);
    check("oor0_rresp", axi_rresp, 0);
    check("oor0_rlast", axi_rlast, 0);
    tick();
    check("oor1_mem_cs", mem_cs, 0);
    tick();
    check("oor1_rresp", axi_rresp, 3);
    check("oor1_rdata", axi_rdata, 0);
    check("oor1_rlast", axi_rlast, 1);
    check("oor1_rid", axi_rid, 9);
    tick();
    axi_rready = 0;
    check("oor_cs_count", cs_count - cs_base, 1);

    // Bad-WRAP read (len 2): 3 SLVERR beats, no strobes
    cs_base = cs_count;
    axi_arvalid = 1; axi_araddr = 32'h20; axi_arlen = 2; axi_arsize = 2; axi_arburst = 2; axi_arid = 2;
    tick();
    axi_arvalid = 0;
    for (int b = 0; b < 3; b++) begin
      check("badr_mem_cs", mem_cs, 0);
      tick();
      axi_rready = 1;
      #1;
      check("badr_rresp", axi_rresp, 2);
      check("badr_rdata", axi_rdata, 0);
      check("badr_rlast", axi_rlast, (b == 2));
      tick();
      axi_rready = 0;
    end
    check("badr_cs_count", cs_count - cs_base, 0);

    // Read back the INCR write
    axi_arvalid = 1; axi_araddr = 32'h10; axi_arlen = 3; axi_arsize = 2; axi_arburst = 1; axi_arid = 4;
    tick();
    axi_arvalid = 0;
    for (int b = 0; b < 4; b++) begin
      check("rb_mem_addr", mem_addr, 4 + b);
      tick();
      axi_rready = 1;
      #1;
      check("rb_rdata", axi_rdata, b + 1);
      tick();
      axi_rready = 0;
    end

    // Reset in the middle of a write burst
    axi_awvalid = 1; axi_awaddr = 32'h100; axi_awlen = 3; axi_awsize = 2; axi_awburst = 1; axi_awid = 1;
    tick();
    axi_awvalid = 0;
    axi_wvalid = 1; axi_wdata = 32'hA5A5A5A5; axi_wstrb = 4'hF;
    #1;
    check("mid_mem_cs", mem_cs, 1);
    tick();
    rst_n = 0;
    #1;
    check("mid_rst_mem_cs", mem_cs, 0);
    tick();
    rst_n = 1;
    axi_wvalid = 0;
    #1;
    check("mid_rst_wready", axi_wready, 0);
    check("mid_rst_bvalid", axi_bvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
